// File: rtl/float_entry_pkg.sv
// float_entry_pkg
//   Shared types and constants for the float operand-entry sequencer.
//   cmd_e    : front-panel command encoding carried on CMD.
//   state_e  : fold sequencer states.
//   exp_bias : IEEE-style exponent bias for a given exponent width.
//   FLOAT_W / NIB : word width and nibble count of the default
//   single-precision configuration (EXP_W=8, MAN_W=23).
package float_entry_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int FLOAT_W   = 1 + EXP_W_DEF + MAN_W_DEF;
    localparam int NIB       = (FLOAT_W + 3) / 4;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_SEL_NEXT = 3'd1,
        CMD_SEL_PREV = 3'd2,
        CMD_EXP_INC  = 3'd3,
        CMD_EXP_DEC  = 3'd4,
        CMD_EXP_BIAS = 3'd5,
        CMD_CLEAR    = 3'd6,
        CMD_GO       = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_entry_sequencer_if.sv
// float_entry_sequencer_if
//   Request/response handshake between the entry sequencer and the
//   external float add/sub unit.
//   REQ_VALID/REQ_READY : request handshake (sequencer -> unit)
//   REQ_A, REQ_B        : operands, REQ_SUB : 0 add / 1 subtract
//   RSP_VALID           : one-cycle response strobe (unit -> sequencer)
//   RSP_R, RSP_OVF, RSP_UNF : result and exception flags
//   master modport = sequencer side, slave modport = arithmetic unit side.
interface float_entry_sequencer_if #(
    parameter int FLOAT_W = float_entry_pkg::FLOAT_W
) ();

    logic               REQ_VALID;
    logic               REQ_READY;
    logic [FLOAT_W-1:0] REQ_A;
    logic [FLOAT_W-1:0] REQ_B;
    logic               REQ_SUB;
    logic               RSP_VALID;
    logic [FLOAT_W-1:0] RSP_R;
    logic               RSP_OVF;
    logic               RSP_UNF;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_SUB,
        input  REQ_READY, RSP_VALID, RSP_R, RSP_OVF, RSP_UNF
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_SUB,
        output REQ_READY, RSP_VALID, RSP_R, RSP_OVF, RSP_UNF
    );

endinterface

// File: rtl/float_nibble_writer.sv
// float_nibble_writer
//   Combinational insert of a 4-bit nibble into a W-bit word.
//   word     : original word
//   nib      : nibble to insert, nib[3] lands on bit 'hi'
//   hi       : bit index of the nibble MSB; nibble occupies [hi -: 4]
//   word_out : word with the nibble inserted; nibble bits that would fall
//              below bit 0 are dropped.
module float_nibble_writer #(
    parameter  int W    = 32,
    localparam int HI_W = $clog2(W)
) (
    input  logic [W-1:0]    word,
    input  logic [3:0]      nib,
    input  logic [HI_W-1:0] hi,
    output logic [W-1:0]    word_out
);

    logic [W-1:0] mask;
    logic [W-1:0] ins;

    // Work in a W+3 wide space with the nibble's LSB at 'hi', then shift
    // down by 3 so that any bits below bit 0 of the word fall off.
    always_comb begin
        mask     = W'(({{(W-1){1'b0}}, 4'hF} << hi) >> 3);
        ins      = W'(({{(W-1){1'b0}}, nib } << hi) >> 3);
        word_out = (word & ~mask) | ins;
    end

endmodule

// File: rtl/float_entry_sequencer.sv
// float_entry_sequencer
//   Operand entry and left-to-right fold sequencer for the float
//   adder/subtractor front panel.
//   CLK, RESET          : clock, asynchronous active-low reset
//   KEY_VALID, KEY_VAL  : key strobe and nibble
//   CMD_VALID, CMD      : command strobe and code (float_entry_pkg::cmd_e)
//   MODE                : 0 exponent-window entry, 1 raw nibble entry
//   SUB                 : operation for the fold, sampled at GO
//   OPERANDS            : all operand registers, op i at [i*FLOAT_W +: FLOAT_W]
//   SEL, CURSOR         : selected operand, raw-mode nibble index
//   KEY_REJECT          : one-cycle pulse when a key is dropped
//   BUSY                : fold in progress
//   bus                 : request/response link to the add/sub unit
//   RESULT, RESULT_VALID, OVF, UNF : fold result, done pulse, flags
module float_entry_sequencer #(
    parameter  int EXP_W   = 8,
    parameter  int MAN_W   = 23,
    parameter  int N_OPS   = 2,
    localparam int FLOAT_W = 1 + EXP_W + MAN_W,
    localparam int NIB     = (FLOAT_W + 3) / 4,
    localparam int SEL_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1,
    localparam int CUR_W   = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     KEY_VALID,
    input  logic [3:0]               KEY_VAL,
    input  logic                     CMD_VALID,
    input  logic [2:0]               CMD,
    input  logic                     MODE,
    input  logic                     SUB,
    output logic [N_OPS*FLOAT_W-1:0] OPERANDS,
    output logic [SEL_W-1:0]         SEL,
    output logic [CUR_W-1:0]         CURSOR,
    output logic                     KEY_REJECT,
    output logic                     BUSY,
    float_entry_sequencer_if.master  bus,
    output logic [FLOAT_W-1:0]       RESULT,
    output logic                     RESULT_VALID,
    output logic                     OVF,
    output logic                     UNF
);

    import float_entry_pkg::*;

    localparam int BIAS    = exp_bias(EXP_W);
    localparam int HI_W    = $clog2(FLOAT_W);
    localparam int EXP_MSB = FLOAT_W - 2;

    logic [FLOAT_W-1:0] ops [N_OPS];

    state_e             state;
    logic [SEL_W-1:0]   idx;
    logic [FLOAT_W-1:0] acc;
    logic [FLOAT_W-1:0] req_b;
    logic               req_valid;
    logic               sub_q;
    logic               ovf_acc;
    logic               unf_acc;

    logic [FLOAT_W-1:0] cur_op;
    logic [EXP_W-1:0]   cur_exp;
    int                 win_k;
    logic               win_ok;
    logic [HI_W-1:0]    raw_hi;
    logic [HI_W-1:0]    win_hi;
    logic [HI_W-1:0]    ins_hi;
    logic [FLOAT_W-1:0] key_word;
    logic               idle;
    logic               key_ok;
    cmd_e               cmd;

    genvar g;
    generate
        for (g = 0; g < N_OPS; g++) begin : g_flat
            assign OPERANDS[g*FLOAT_W +: FLOAT_W] = ops[g];
        end
    endgenerate

    assign bus.REQ_VALID = req_valid;
    assign bus.REQ_A     = acc;
    assign bus.REQ_B     = req_b;
    assign bus.REQ_SUB   = sub_q;

    assign cmd    = cmd_e'(CMD);
    assign idle   = (state == ST_IDLE);
    assign cur_op = ops[SEL];
    assign cur_exp = cur_op[EXP_MSB -: EXP_W];

    // Window mode: the unbiased exponent k picks which mantissa nibble a
    // key lands on, so the key edits the digit just right of the binary
    // point's current position. Keys outside the mantissa are rejected.
    always_comb begin
        win_k  = int'(cur_exp) - BIAS;
        win_ok = (win_k >= 0) && (win_k <= MAN_W - 4);
        raw_hi = HI_W'(FLOAT_W - 1 - 4 * int'(CURSOR));
        win_hi = win_ok ? HI_W'(MAN_W - 1 - win_k) : '0;
        ins_hi = MODE ? raw_hi : win_hi;
    end

    // A simultaneous command wins over a key; nothing is editable mid-fold.
    assign key_ok = KEY_VALID && !CMD_VALID && idle && (MODE || win_ok);

    float_nibble_writer #(
        .W (FLOAT_W)
    ) u_writer (
        .word     (cur_op),
        .nib      (KEY_VAL),
        .hi       (ins_hi),
        .word_out (key_word)
    );

    // Operand editing: key inserts and front-panel commands.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int n = 0; n < N_OPS; n++) begin
                ops[n] <= '0;
            end
            SEL        <= '0;
            CURSOR     <= '0;
            KEY_REJECT <= 1'b0;
        end else begin
            KEY_REJECT <= KEY_VALID && !key_ok;
            if (key_ok) begin
                ops[SEL] <= key_word;
                if (MODE) begin
                    CURSOR <= (CURSOR == CUR_W'(NIB - 1)) ? '0 : CURSOR + CUR_W'(1);
                end
            end
            if (CMD_VALID && idle) begin
                case (cmd)
                    CMD_SEL_NEXT: begin
                        SEL    <= (SEL == SEL_W'(N_OPS - 1)) ? '0 : SEL + SEL_W'(1);
                        CURSOR <= '0;
                    end
                    CMD_SEL_PREV: begin
                        SEL    <= (SEL == '0) ? SEL_W'(N_OPS - 1) : SEL - SEL_W'(1);
                        CURSOR <= '0;
                    end
                    CMD_EXP_INC:  ops[SEL][EXP_MSB -: EXP_W] <= cur_exp + EXP_W'(1);
                    CMD_EXP_DEC:  ops[SEL][EXP_MSB -: EXP_W] <= cur_exp - EXP_W'(1);
                    CMD_EXP_BIAS: ops[SEL][EXP_MSB -: EXP_W] <= EXP_W'(BIAS);
                    CMD_CLEAR: begin
                        ops[SEL] <= '0;
                        CURSOR   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Fold sequencer: acc = op0, then acc = acc (+/-) op[i] for i = 1..N_OPS-1.
    // OVF/UNF accumulate internally and only reach the outputs at DONE so
    // the previous fold's flags stay visible while a new fold runs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            idx          <= '0;
            acc          <= '0;
            req_b        <= '0;
            req_valid    <= 1'b0;
            sub_q        <= 1'b0;
            ovf_acc      <= 1'b0;
            unf_acc      <= 1'b0;
            BUSY         <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            OVF          <= 1'b0;
            UNF          <= 1'b0;
        end else begin
            RESULT_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID && cmd == CMD_GO) begin
                        acc       <= ops[0];
                        req_b     <= ops[1];
                        idx       <= SEL_W'(1);
                        sub_q     <= SUB;
                        ovf_acc   <= 1'b0;
                        unf_acc   <= 1'b0;
                        BUSY      <= 1'b1;
                        req_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.REQ_READY) begin
                        req_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.RSP_VALID) begin
                        acc     <= bus.RSP_R;
                        ovf_acc <= ovf_acc | bus.RSP_OVF;
                        unf_acc <= unf_acc | bus.RSP_UNF;
                        if (idx == SEL_W'(N_OPS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            idx       <= idx + SEL_W'(1);
                            req_b     <= ops[idx + SEL_W'(1)];
                            req_valid <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    RESULT       <= acc;
                    RESULT_VALID <= 1'b1;
                    OVF          <= ovf_acc;
                    UNF          <= unf_acc;
                    BUSY         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
